// File: rtl/register_iff_ctrl_pkg.sv
// Shared codes for the interrupt flip-flop controller: state encoding, IM encoding, IM decode.
// Pure definitions; no timing or flow control of its own.
package register_iff_ctrl_pkg;

    typedef enum logic [1:0] {
        IFF_ST_RUN     = 2'd0,
        IFF_ST_NMI_ACK = 2'd1,
        IFF_ST_INT_ACK = 2'd2
    } iff_state_e;

    localparam logic [1:0] IM_MODE0 = 2'd0;
    localparam logic [1:0] IM_MODE1 = 2'd1;
    localparam logic [1:0] IM_MODE2 = 2'd2;

    // IM 3 has no distinct behaviour and aliases to mode 1.
    function automatic logic [1:0] im_decode(input logic [1:0] op_im);
        return (op_im == 2'd3) ? IM_MODE1 : op_im;
    endfunction

endpackage

// File: rtl/register_iff_ctrl_if.sv
// Sequencer/pin bundle for register_iff_ctrl: boundary/op strobes, interrupt pins, ack handshake.
// The master drives strobes and pins; the slave returns the ack levels and IFF/IM state.
interface register_iff_ctrl_if;
    logic       InstrEnd;
    logic       Op_EI;
    logic       Op_DI;
    logic       Op_RETN;
    logic       Op_IMWrite;
    logic [1:0] Op_IM;
    logic       notNMI;
    logic       notINT;
    logic       AckDone;
    logic       NmiAck;
    logic       IntAck;
    logic       IFF1;
    logic       IFF2;
    logic [1:0] IM;

    modport master (
        output InstrEnd, Op_EI, Op_DI, Op_RETN, Op_IMWrite, Op_IM,
        output notNMI, notINT, AckDone,
        input  NmiAck, IntAck, IFF1, IFF2, IM
    );

    modport slave (
        input  InstrEnd, Op_EI, Op_DI, Op_RETN, Op_IMWrite, Op_IM,
        input  notNMI, notINT, AckDone,
        output NmiAck, IntAck, IFF1, IFF2, IM
    );
endinterface

// File: rtl/register_sync.sv
// N-stage synchronizer that resets to 1 (an idle active-low pin); latency STAGES cycles.
// No flow control: samples every cycle.
module register_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/register_iff_ctrl.sv
// IFF1/IFF2/IM owner with NMI edge / INT level acceptance at instruction boundaries; acks are registered.
// Optional REGISTER_IFF_SYNC_EN adds SYNC_STAGES cycles of pin latency; ack is held until AckDone.
module register_iff_ctrl
    import register_iff_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clk,
    input  logic                 notReset,
    register_iff_ctrl_if.slave   bus
);
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be at least 2");
    end

    logic nmi_pin;
    logic int_pin;

`ifdef REGISTER_IFF_SYNC_EN
    register_sync #(.STAGES(SYNC_STAGES)) u_sync_nmi (
        .clk(Clk), .rst_n(notReset), .d(bus.notNMI), .q(nmi_pin)
    );
    register_sync #(.STAGES(SYNC_STAGES)) u_sync_int (
        .clk(Clk), .rst_n(notReset), .d(bus.notINT), .q(int_pin)
    );
`else
    assign nmi_pin = bus.notNMI;
    assign int_pin = bus.notINT;
`endif

    iff_state_e state_q, state_d;
    logic       iff1_q, iff1_d;
    logic       iff2_q, iff2_d;
    logic [1:0] im_q, im_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_prev_q, nmi_prev_d;
    logic       nmi_ack_q, nmi_ack_d;
    logic       int_ack_q, int_ack_d;
    logic       nmi_edge;
    logic       op_iff1;
    logic       op_iff2;
    logic       ei_taken;

    always_comb begin
        state_d    = state_q;
        iff1_d     = iff1_q;
        iff2_d     = iff2_q;
        im_d       = im_q;
        nmi_prev_d = nmi_pin;
        nmi_edge   = nmi_prev_q & ~nmi_pin;
        nmi_pend_d = nmi_pend_q | nmi_edge;
        op_iff1    = iff1_q;
        op_iff2    = iff2_q;
        ei_taken   = 1'b0;

        case (state_q)
            IFF_ST_RUN: begin
                if (bus.InstrEnd) begin
                    if (bus.Op_DI) begin
                        op_iff1 = 1'b0;
                        op_iff2 = 1'b0;
                    end else if (bus.Op_EI) begin
                        op_iff1  = 1'b1;
                        op_iff2  = 1'b1;
                        ei_taken = 1'b1;
                    end else if (bus.Op_RETN) begin
                        op_iff1 = iff2_q;
                    end
                    if (bus.Op_IMWrite) begin
                        im_d = im_decode(bus.Op_IM);
                    end
                    iff1_d = op_iff1;
                    iff2_d = op_iff2;
                    // EI shadows its own boundary only, so acceptance lands one instruction later.
                    if (!ei_taken) begin
                        if (nmi_pend_q) begin
                            state_d    = IFF_ST_NMI_ACK;
                            iff2_d     = op_iff1;
                            iff1_d     = 1'b0;
                            nmi_pend_d = nmi_edge;
                        end else if (!int_pin && op_iff1) begin
                            state_d = IFF_ST_INT_ACK;
                            iff1_d  = 1'b0;
                            iff2_d  = 1'b0;
                        end
                    end
                end
            end
            IFF_ST_NMI_ACK, IFF_ST_INT_ACK: begin
                if (bus.AckDone) begin
                    state_d = IFF_ST_RUN;
                end
            end
            default: state_d = IFF_ST_RUN;
        endcase

        nmi_ack_d = (state_d == IFF_ST_NMI_ACK);
        int_ack_d = (state_d == IFF_ST_INT_ACK);
    end

    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            state_q    <= IFF_ST_RUN;
            iff1_q     <= 1'b0;
            iff2_q     <= 1'b0;
            im_q       <= IM_MODE0;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= 1'b1;
            nmi_ack_q  <= 1'b0;
            int_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            iff1_q     <= iff1_d;
            iff2_q     <= iff2_d;
            im_q       <= im_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_ack_q  <= nmi_ack_d;
            int_ack_q  <= int_ack_d;
        end
    end

    assign bus.NmiAck = nmi_ack_q;
    assign bus.IntAck = int_ack_q;
    assign bus.IFF1   = iff1_q;
    assign bus.IFF2   = iff2_q;
    assign bus.IM     = im_q;
endmodule

// File: tb/tb_register_iff_ctrl.sv
// Directed bench for register_iff_ctrl with a cycle-level reference model and literal spot checks.
module tb_register_iff_ctrl;
    logic Clk;
    logic notReset;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 0;
    int   nmi_rises;
    bit   prev_nmiack;

    register_iff_ctrl_if bus();

    register_iff_ctrl #(.SYNC_STAGES(2)) dut (
        .Clk      (Clk),
        .notReset (notReset),
        .bus      (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: mode 0 = running, 1 = NMI ack, 2 = INT ack.
    bit       m_iff1 = 0;
    bit       m_iff2 = 0;
    bit [1:0] m_im = 0;
    int       m_mode = 0;
    bit       m_pend = 0;
    bit       m_pin_prev = 1;

    always @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            m_iff1 = 0; m_iff2 = 0; m_im = 0; m_mode = 0; m_pend = 0; m_pin_prev = 1;
        end else begin : model_step
            bit fell;
            bit ei_now;
            fell = m_pin_prev && !bus.notNMI;
            m_pin_prev = bus.notNMI;
            if (m_mode == 0 && bus.InstrEnd) begin
                ei_now = bus.Op_EI && !bus.Op_DI;
                if (bus.Op_DI) begin m_iff1 = 0; m_iff2 = 0; end
                else if (bus.Op_EI) begin m_iff1 = 1; m_iff2 = 1; end
                else if (bus.Op_RETN) m_iff1 = m_iff2;
                if (bus.Op_IMWrite) m_im = (bus.Op_IM == 2'd3) ? 2'd1 : bus.Op_IM;
                if (!ei_now && m_pend) begin
                    m_iff2 = m_iff1; m_iff1 = 0; m_pend = 0; m_mode = 1;
                end else if (!ei_now && !bus.notINT && m_iff1) begin
                    m_iff1 = 0; m_iff2 = 0; m_mode = 2;
                end
            end else if (m_mode != 0 && bus.AckDone) begin
                m_mode = 0;
            end
            if (fell) m_pend = 1;
        end
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("cmp_NmiAck", bus.NmiAck, (m_mode == 1));
            check("cmp_IntAck", bus.IntAck, (m_mode == 2));
            check("cmp_IFF1",   bus.IFF1,   m_iff1);
            check("cmp_IFF2",   bus.IFF2,   m_iff2);
            check("cmp_IM",     bus.IM,     m_im);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic boundary(input bit ei, input bit di, input bit retn, input bit imw,
                            input logic [1:0] im);
        bus.InstrEnd = 1'b1; bus.Op_EI = ei; bus.Op_DI = di; bus.Op_RETN = retn;
        bus.Op_IMWrite = imw; bus.Op_IM = im;
        tick();
        bus.InstrEnd = 1'b0; bus.Op_EI = 1'b0; bus.Op_DI = 1'b0; bus.Op_RETN = 1'b0;
        bus.Op_IMWrite = 1'b0; bus.Op_IM = 2'd0;
    endtask

    task automatic ack();
        bus.AckDone = 1'b1;
        tick();
        bus.AckDone = 1'b0;
    endtask

    task automatic nmi_pulse();
        bus.notNMI = 1'b0;
        tick();
        bus.notNMI = 1'b1;
    endtask

    initial begin
        notReset = 1'b0;
        bus.InstrEnd = 0; bus.Op_EI = 0; bus.Op_DI = 0; bus.Op_RETN = 0;
        bus.Op_IMWrite = 0; bus.Op_IM = 0; bus.notNMI = 1; bus.notINT = 1; bus.AckDone = 0;
        tick();
        cmp_en = 1;
        tick(); tick();
        notReset = 1'b1;
        tick();
        check("rst_IFF1", bus.IFF1, 0);
        check("rst_IFF2", bus.IFF2, 0);
        check("rst_IM", bus.IM, 0);
        check("rst_NmiAck", bus.NmiAck, 0);
        check("rst_IntAck", bus.IntAck, 0);

        // DI and INT on the same boundary: DI wins, nothing accepted.
        boundary(1, 0, 0, 0, 0);
        boundary(0, 0, 0, 0, 0);
        check("ei_IFF1", bus.IFF1, 1);
        bus.notINT = 1'b0;
        boundary(0, 1, 0, 0, 0);
        check("di_IntAck", bus.IntAck, 0);
        check("di_IFF1", bus.IFF1, 0);
        check("di_IFF2", bus.IFF2, 0);
        tick();
        check("di_IntAck_late", bus.IntAck, 0);

        // EI shadow: INT held low, accepted one boundary after EI.
        boundary(1, 0, 0, 0, 0);
        check("shd_IntAck_k", bus.IntAck, 0);
        check("shd_IFF1_k", bus.IFF1, 1);
        tick(); tick();
        check("shd_IntAck_gap", bus.IntAck, 0);
        boundary(0, 0, 0, 0, 0);
        check("shd_IntAck_k1", bus.IntAck, 1);
        check("shd_IFF1_acc", bus.IFF1, 0);
        check("shd_IFF2_acc", bus.IFF2, 0);
        tick();
        ack();
        check("shd_IntAck_done", bus.IntAck, 0);
        bus.notINT = 1'b1;

        // NMI save/restore through RETN.
        boundary(1, 0, 0, 0, 0);
        boundary(0, 0, 0, 0, 0);
        nmi_pulse();
        tick(); tick();
        boundary(0, 0, 0, 0, 0);
        check("nmi_NmiAck", bus.NmiAck, 1);
        check("nmi_IFF1", bus.IFF1, 0);
        check("nmi_IFF2", bus.IFF2, 1);
        ack();
        check("nmi_NmiAck_done", bus.NmiAck, 0);
        boundary(0, 0, 1, 0, 0);
        check("retn_IFF1", bus.IFF1, 1);
        check("retn_IFF2", bus.IFF2, 1);

        // NMI edge during an INT acknowledge is retained.
        bus.notINT = 1'b0;
        boundary(0, 0, 0, 0, 0);
        check("ni_IntAck", bus.IntAck, 1);
        bus.notINT = 1'b1;
        nmi_pulse();
        tick(); tick();
        check("ni_NmiAck_wait", bus.NmiAck, 0);
        check("ni_IntAck_hold", bus.IntAck, 1);
        ack();
        check("ni_IntAck_done", bus.IntAck, 0);
        check("ni_NmiAck_noboundary", bus.NmiAck, 0);
        boundary(0, 0, 0, 0, 0);
        check("ni_NmiAck", bus.NmiAck, 1);
        check("ni_IFF2", bus.IFF2, 0);
        ack();

        // IM writes.
        boundary(0, 0, 0, 1, 2'd3);
        check("im3_IM", bus.IM, 1);
        boundary(0, 0, 0, 1, 2'd2);
        check("im2_IM", bus.IM, 2);

        // NMI held low for 100 cycles produces a single acknowledge.
        nmi_rises = 0;
        prev_nmiack = 0;
        bus.notNMI = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.InstrEnd = ((i % 5) == 4);
            bus.AckDone = bus.NmiAck;
            tick();
            if (bus.NmiAck && !prev_nmiack) nmi_rises++;
            prev_nmiack = bus.NmiAck;
        end
        bus.notNMI = 1'b1; bus.InstrEnd = 1'b0; bus.AckDone = 1'b0;
        tick(); tick();
        check("hold_nmi_count", nmi_rises[1:0], 1);
        check("hold_IM", bus.IM, 2);

        // Reset in the middle of an INT acknowledge with an NMI pending.
        boundary(1, 0, 0, 0, 0);
        boundary(0, 0, 0, 0, 0);
        bus.notINT = 1'b0;
        boundary(0, 0, 0, 0, 0);
        check("rmid_IntAck", bus.IntAck, 1);
        nmi_pulse();
        #2;
        notReset = 1'b0;
        #1;
        check("rmid_IntAck_clr", bus.IntAck, 0);
        check("rmid_NmiAck_clr", bus.NmiAck, 0);
        check("rmid_IFF1", bus.IFF1, 0);
        check("rmid_IFF2", bus.IFF2, 0);
        check("rmid_IM", bus.IM, 0);
        tick(); tick();
        notReset = 1'b1;
        bus.notINT = 1'b1;
        boundary(1, 0, 0, 0, 0);
        boundary(0, 0, 0, 0, 0);
        check("rmid_nmi_lost", bus.NmiAck, 0);
        check("rmid_IFF1_after", bus.IFF1, 1);
        tick(); tick();

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
